alu_pipe: RTL and testbench

Parametrised, handshaked successor to the 4-bit combinational ALU. It takes a WIDTH-bit operand pair and a 4-bit opcode through a valid/ready input port and returns a registered result plus carry, zero, negative and overflow flags through a valid/ready output port. Single-cycle ops run at full throughput. MUL is an iterative shift-add taking WIDTH cycles. It sits between an operand source (sequencer/register file) and a result consumer that may stall.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 90 +++++++++
 rtl/alu_pipe.sv | 141 ++++++++++++++
 tb/tb_alu_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, sequencer state
// encoding and the registered flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// product/hi_nz reflect the accumulator after the current step, so they are
// valid in the same cycle that done is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             hi_nz
);

  localparam int CW = $clog2(WIDTH);

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign last_step = (state_q == ST_BUSY) && (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_BUSY;
          count_d  = {CW{1'b0}};
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = {(2*WIDTH){1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (last_step) begin
          state_d = ST_IDLE;
          count_d = {CW{1'b0}};
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= {CW{1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy    = (state_q == ST_BUSY);
  assign done    = last_step;
  assign product = acc_step[WIDTH-1:0];
  assign hi_nz   = |acc_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops registered with latency 1, MUL delegated
// to the iterative multiplier. One output register with valid/ready hold.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  function automatic alu_flags_t pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    alu_flags_t f;
    f.carry    = c;
    f.zero     = (r == {WIDTH{1'b0}});
    f.negative = r[WIDTH-1];
    f.overflow = v;
    return f;
  endfunction

  logic             accept, mul_start, mul_busy, mul_done, mul_hi_nz;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;
  logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  assign in_ready  = !rst && !mul_busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  // Extra bit on each side of the shifters captures the last bit shifted out.
  assign shamt    = b[SHW-1:0];
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign shl_full = {1'b0, a} << shamt;
  assign shr_full = {a, 1'b0} >> shamt;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .hi_nz   (mul_hi_nz)
  );

  always_comb begin
    alu_res   = {WIDTH{1'b0}};
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res   = shl_full[WIDTH-1:0];
        alu_carry = shl_full[WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_full[WIDTH:1];
        alu_carry = shr_full[0];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = {WIDTH{1'b0}};
    endcase
  end

  // A MUL completion can never coincide with an accept: in_ready is low while busy.
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (mul_done) begin
      result_d    = mul_product;
      flags_d     = pack_flags(mul_product, mul_hi_nz, 1'b0);
      out_valid_d = 1'b1;
    end else if (accept && !mul_start) begin
      result_d    = alu_res;
      flags_d     = pack_flags(alu_res, alu_carry, alu_ovf);
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed cases plus a random
// stream checked against an integer-arithmetic reference and a result queue.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, zero, negative, overflow;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int c;
    int z;
    int n;
    int v;
    int due;
    int mul;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU from the opcode table, using plain signed/unsigned integers.
  function automatic exp_t ref_alu(input int o, input int x, input int y);
    exp_t e;
    int sx, sy, full, sh;
    sx = (x >= HALF) ? x - (MASK + 1) : x;
    sy = (y >= HALF) ? y - (MASK + 1) : y;
    e.c = 0; e.v = 0; e.due = 0; e.mul = 0;
    sh = y % W;
    case (o)
      0: begin full = x + y; e.c = (full > MASK); e.v = (sx + sy > HALF - 1) || (sx + sy < -HALF); end
      1: begin full = x - y; e.c = (x < y);       e.v = (sx - sy > HALF - 1) || (sx - sy < -HALF); end
      2: full = x & y;
      3: full = x | y;
      4: full = x ^ y;
      5: full = ~x;
      6: begin full = x << sh; e.c = (sh != 0) && (((x >> (W - sh)) & 1) == 1); end
      7: begin full = x >> sh; e.c = (sh != 0) && (((x >> (sh - 1)) & 1) == 1); end
      8: full = (sx < sy) ? 1 : 0;
      9: begin full = x * y; e.c = (full > MASK); end
      default: full = 0;
    endcase
    e.res = full & MASK;
    e.z   = (e.res == 0);
    e.n   = (e.res >= HALF);
    return e;
  endfunction

  // One clock: check outputs against the queue head, drive inputs, update the model.
  task automatic cycle(input bit iv, input int o, input int x, input int y, input bit ordy);
    bit   exp_valid, busy, exp_rdy;
    int   xv, yv, ov;
    exp_t e;
    exp_valid = (q.size() > 0) && (q[0].due <= cyc);
    check_eq("out_valid", int'(out_valid), int'(exp_valid));
    if (exp_valid) begin
      check_eq("result",   int'(result),   q[0].res);
      check_eq("carry",    int'(carry),    q[0].c);
      check_eq("zero",     int'(zero),     q[0].z);
      check_eq("negative", int'(negative), q[0].n);
      check_eq("overflow", int'(overflow), q[0].v);
    end
    xv = x & MASK; yv = y & MASK; ov = o & 15;
    in_valid  = iv;
    op        = ov[3:0];
    a         = xv[W-1:0];
    b         = yv[W-1:0];
    out_ready = ordy;
    #1;
    busy = 1'b0;
    foreach (q[i]) if (q[i].mul != 0 && q[i].due > cyc) busy = 1'b1;
    exp_rdy = !busy && (!exp_valid || ordy);
    check_eq("in_ready", int'(in_ready), int'(exp_rdy));
    if (exp_valid && ordy) void'(q.pop_front());
    if (iv && exp_rdy) begin
      e     = ref_alu(ov, xv, yv);
      e.mul = (ov == 9);
      e.due = cyc + 1 + ((ov == 9) ? W : 0);
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      #1;
      check_eq("rst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    q.delete();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input int r, input int c, input int z,
                           input int n, input int v, input int vld);
    check_eq({tag, "_valid"}, int'(out_valid), vld);
    check_eq({tag, "_res"},   int'(result),    r);
    check_eq({tag, "_c"},     int'(carry),     c);
    check_eq({tag, "_z"},     int'(zero),      z);
    check_eq({tag, "_n"},     int'(negative),  n);
    check_eq({tag, "_v"},     int'(overflow),  v);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);
    check_out("reset", 0, 0, 0, 0, 0, 0);

    cycle(1'b1, 0, 'hFF, 'h01, 1'b1);  check_out("add_ff_01", 'h00, 1, 1, 0, 0, 1);
    cycle(1'b1, 1, 'h80, 'h01, 1'b1);  check_out("sub_80_01", 'h7F, 0, 0, 0, 1, 1);
    cycle(1'b1, 1, 'h01, 'h02, 1'b1);  check_out("sub_01_02", 'hFF, 1, 0, 1, 0, 1);

    // MUL: inputs presented while busy must be ignored.
    cycle(1'b1, 9, 'h10, 'h11, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b1, 0, 'h55, 'h22, 1'b1);
    check_out("mul_10_11", 'h10, 1, 0, 0, 0, 1);

    // Backpressure then simultaneous consume/accept.
    cycle(1'b0, 0, 0, 0, 1'b1);
    cycle(1'b1, 0, 'h03, 'h04, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4, 'h0F, 'hF0, 1'b0);
    check_out("bp_hold", 'h07, 0, 0, 0, 0, 1);
    check_eq("bp_in_ready", int'(in_ready), 0);
    cycle(1'b1, 4, 'h0F, 'hF0, 1'b1);  check_out("xor_0f_f0", 'hFF, 0, 0, 1, 0, 1);

    cycle(1'b1, 6, 'h81, 'h01, 1'b1);  check_out("shl_81_1", 'h02, 1, 0, 0, 0, 1);
    cycle(1'b1, 7, 'h01, 'h00, 1'b1);  check_out("shr_01_0", 'h01, 0, 0, 0, 0, 1);
    cycle(1'b1, 8, 'hFF, 'h01, 1'b1);  check_out("slt_ff_01", 'h01, 0, 0, 0, 0, 1);

    // Reset lands on the third multiply step.
    cycle(1'b1, 9, 'h10, 'h11, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b1);
    do_reset(1);
    check_out("mul_abort", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < W + 2; i++) cycle(1'b0, 0, 0, 0, 1'b1);
    cycle(1'b1, 0, 'h01, 'h01, 1'b1);  check_out("add_01_01", 'h02, 0, 0, 0, 0, 1);
    cycle(1'b1, 15, 'h5A, 'h33, 1'b1); check_out("illegal_f", 'h00, 0, 1, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15),
              $urandom_range(0, MASK), $urandom_range(0, MASK),
              $urandom_range(0, 3) != 0);
      end
    end

    for (int i = 0; i < 4 * W && q.size() > 0; i++) cycle(1'b0, 0, 0, 0, 1'b1);
    check_eq("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
